// File: rtl/controle_vidas_if.sv
// Link between the life sequencer and the decrementador counter it steers.
interface controle_vidas_if #(parameter int N = 4);
  logic [N-1:0] vidas;
  logic         vidas_zero;
  logic         dec_clr;
  logic         dec_en;
  logic         dec_ld;
  logic [N-1:0] dec_d;

  modport master (input vidas, vidas_zero, output dec_clr, dec_en, dec_ld, dec_d);
  modport slave  (output vidas, vidas_zero, input dec_clr, dec_en, dec_ld, dec_d);
endinterface

// File: rtl/controle_vidas.sv
// Player life sequencer: round-robin hit arbitration, invulnerability window,
// extra-life loads and sticky game-over, driving an external decrementador.
module controle_vidas #(
  parameter int N          = 4,
  parameter int N_SRC      = 4,
  parameter int INV_CYCLES = 8,
  parameter int MAX_VIDAS  = 5
) (
  input  logic             clock,
  input  logic             clr_n,
  input  logic             restart,
  input  logic [N_SRC-1:0] hit_req,
  input  logic             bonus,
  output logic [N_SRC-1:0] hit_ack,
  output logic             invuln,
  output logic             game_over,
  controle_vidas_if.master dec
);
  localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int INV_W = $clog2(INV_CYCLES + 1);

  typedef enum logic [2:0] {INIT, IDLE, DEC, SETTLE, INVULN, LOAD, OVER} state_t;

  state_t           state_reg, state_next;
  logic [PTR_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic             bonus_pend_reg, bonus_pend_next;
  logic [INV_W-1:0] inv_cnt_reg, inv_cnt_next;
  logic             dec_clr_reg, dec_clr_next;
  logic             dec_en_reg, dec_en_next;
  logic             dec_ld_reg, dec_ld_next;
  logic [N-1:0]     dec_d_reg, dec_d_next;
  logic [N_SRC-1:0] hit_ack_reg, hit_ack_next;
  logic             invuln_reg, invuln_next;
  logic             game_over_reg, game_over_next;

  logic [N_SRC-1:0] upper_mask, upper_req, pick_req, grant_onehot;
  logic [PTR_W-1:0] grant_idx;
  logic             can_load;

  // Requests at or above the pointer win; otherwise wrap to the lowest index.
  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_arb
      assign upper_mask[gi]   = (gi >= int'(rr_ptr_reg));
      assign grant_onehot[gi] = (gi == int'(grant_idx));
    end
  endgenerate

  assign upper_req = hit_req & upper_mask;
  assign pick_req  = (|upper_req) ? upper_req : hit_req;
  assign can_load  = (dec.vidas < N'(MAX_VIDAS));

  always_comb begin
    grant_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (pick_req[i]) grant_idx = PTR_W'(i);
    end
  end

  always_comb begin
    state_next      = state_reg;
    rr_ptr_next     = rr_ptr_reg;
    bonus_pend_next = bonus_pend_reg;
    inv_cnt_next    = inv_cnt_reg;
    dec_clr_next    = 1'b0;
    dec_en_next     = 1'b0;
    dec_ld_next     = 1'b0;
    dec_d_next      = '0;
    hit_ack_next    = '0;
    invuln_next     = 1'b0;
    game_over_next  = 1'b0;

    // A bonus that arrives while busy is remembered for the next IDLE visit.
    if (bonus && (state_reg inside {DEC, SETTLE, INVULN, LOAD}))
      bonus_pend_next = 1'b1;

    case (state_reg)
      INIT: begin
        dec_clr_next = ~dec_clr_reg;
        if (dec_clr_reg) state_next = IDLE;
      end
      IDLE: begin
        if (|hit_req) begin
          state_next   = DEC;
          dec_en_next  = 1'b1;
          hit_ack_next = grant_onehot;
          rr_ptr_next  = (int'(grant_idx) == N_SRC - 1) ? '0 : grant_idx + PTR_W'(1);
          if (bonus) bonus_pend_next = 1'b1;
        end else if (bonus || bonus_pend_reg) begin
          bonus_pend_next = 1'b0;
          if (can_load) begin
            state_next  = LOAD;
            dec_ld_next = 1'b1;
            dec_d_next  = dec.vidas + N'(1);
          end
        end
      end
      DEC: state_next = SETTLE;
      SETTLE: begin
        if (dec.vidas_zero) begin
          state_next     = OVER;
          game_over_next = 1'b1;
        end else begin
          state_next   = INVULN;
          invuln_next  = 1'b1;
          inv_cnt_next = INV_W'(INV_CYCLES - 1);
        end
      end
      INVULN: begin
        hit_ack_next = hit_req;
        if (inv_cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          invuln_next  = 1'b1;
          inv_cnt_next = inv_cnt_reg - INV_W'(1);
        end
      end
      LOAD: state_next = IDLE;
      OVER: begin
        game_over_next = 1'b1;
        hit_ack_next   = hit_req;
      end
      default: state_next = INIT;
    endcase

    if (restart) begin
      state_next      = INIT;
      dec_clr_next    = 1'b1;
      dec_en_next     = 1'b0;
      dec_ld_next     = 1'b0;
      dec_d_next      = '0;
      hit_ack_next    = '0;
      invuln_next     = 1'b0;
      game_over_next  = 1'b0;
      bonus_pend_next = 1'b0;
      inv_cnt_next    = '0;
    end
  end

  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      state_reg      <= INIT;
      rr_ptr_reg     <= '0;
      bonus_pend_reg <= 1'b0;
      inv_cnt_reg    <= '0;
      dec_clr_reg    <= 1'b0;
      dec_en_reg     <= 1'b0;
      dec_ld_reg     <= 1'b0;
      dec_d_reg      <= '0;
      hit_ack_reg    <= '0;
      invuln_reg     <= 1'b0;
      game_over_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rr_ptr_reg     <= rr_ptr_next;
      bonus_pend_reg <= bonus_pend_next;
      inv_cnt_reg    <= inv_cnt_next;
      dec_clr_reg    <= dec_clr_next;
      dec_en_reg     <= dec_en_next;
      dec_ld_reg     <= dec_ld_next;
      dec_d_reg      <= dec_d_next;
      hit_ack_reg    <= hit_ack_next;
      invuln_reg     <= invuln_next;
      game_over_reg  <= game_over_next;
    end
  end

  assign dec.dec_clr = dec_clr_reg;
  assign dec.dec_en  = dec_en_reg;
  assign dec.dec_ld  = dec_ld_reg;
  assign dec.dec_d   = dec_d_reg;
  assign hit_ack     = hit_ack_reg;
  assign invuln      = invuln_reg;
  assign game_over   = game_over_reg;
endmodule

// File: tb/tb_controle_vidas.sv
// Directed bench for controle_vidas with a behavioural decrementador and an
// event scoreboard for the dec_clr / dec_en / dec_ld pulses.
module tb_controle_vidas;
  localparam int N = 4, N_SRC = 4, INV_CYCLES = 8, MAX_VIDAS = 5;
  localparam int K_CLR = 0, K_EN = 1, K_LD = 2;

  typedef struct {
    int       kind;
    logic [3:0] ack;
    logic [3:0] d;
  } exp_t;

  logic       clock = 1'b0;
  logic       clr_n = 1'b0;
  logic       restart = 1'b0;
  logic       bonus = 1'b0;
  logic [3:0] hit_req = 4'b0000;
  logic [3:0] hit_ack;
  logic       invuln, game_over;
  logic [3:0] q;
  int         checks = 0;
  int         errors = 0;
  exp_t       sb[$];

  controle_vidas_if #(.N(N)) dec_if ();

  controle_vidas #(.N(N), .N_SRC(N_SRC), .INV_CYCLES(INV_CYCLES), .MAX_VIDAS(MAX_VIDAS)) dut (
    .clock     (clock),
    .clr_n     (clr_n),
    .restart   (restart),
    .hit_req   (hit_req),
    .bonus     (bonus),
    .hit_ack   (hit_ack),
    .invuln    (invuln),
    .game_over (game_over),
    .dec       (dec_if)
  );

  always #5 clock = ~clock;

  // Decrementador: clr reloads 3, ld loads D, enable counts down saturating at 0.
  always @(posedge clock or negedge clr_n) begin
    if (!clr_n)               q <= 4'd0;
    else if (dec_if.dec_clr)  q <= 4'd3;
    else if (dec_if.dec_ld)   q <= dec_if.dec_d;
    else if (dec_if.dec_en && q != 4'd0) q <= q - 4'd1;
  end
  assign dec_if.vidas      = q;
  assign dec_if.vidas_zero = (q == 4'd0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [3:0] ack, input logic [3:0] d);
    exp_t e;
    e.kind = kind;
    e.ack  = ack;
    e.d    = d;
    sb.push_back(e);
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_invuln(input string name);
    int n = 0;
    while (!invuln && n < 20) begin n++; cyc(); end
    chk(name, 32'(invuln), 1);
  endtask

  task automatic wait_window_end(input string name, output int width);
    width = 0;
    while (invuln && width < 50) begin width++; cyc(); end
    chk(name, 32'(invuln), 0);
  endtask

  task automatic monitor();
    exp_t e;
    int   k;
    forever begin
      @(negedge clock);
      if (clr_n && (dec_if.dec_clr || dec_if.dec_en || dec_if.dec_ld)) begin
        k = dec_if.dec_clr ? K_CLR : (dec_if.dec_en ? K_EN : K_LD);
        chk("dec_exclusive", 32'(dec_if.dec_clr) + 32'(dec_if.dec_en) + 32'(dec_if.dec_ld), 1);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got kind %0d, expected no event", k);
        end else begin
          e = sb.pop_front();
          chk("event_kind", 32'(k), 32'(e.kind));
          if (k == K_EN) chk("grant_ack", 32'(hit_ack), 32'(e.ack));
          if (k == K_LD) chk("bonus_d", 32'(dec_if.dec_d), 32'(e.d));
        end
      end
    end
  endtask

  initial begin
    int w;
    fork
      monitor();
    join_none

    // Reset and INIT clear pulse
    cyc(2);
    chk("reset_outputs", 32'({dec_if.dec_clr, dec_if.dec_en, dec_if.dec_ld, dec_if.dec_d,
                               hit_ack, invuln, game_over}), 0);
    expect_ev(K_CLR, 4'b0, 4'd0);
    clr_n = 1'b1;
    cyc();
    chk("init_clr_pulse", 32'(dec_if.dec_clr), 1);
    cyc();
    chk("init_clr_one_cycle", 32'(dec_if.dec_clr), 0);
    chk("init_vidas", 32'(dec_if.vidas), 3);

    // Single hit from source 0
    expect_ev(K_EN, 4'b0001, 4'd0);
    hit_req = 4'b0001;
    cyc();
    hit_req = 4'b0000;
    chk("hit_latency_dec_en", 32'(dec_if.dec_en), 1);
    chk("hit_ack_first", 32'(hit_ack), 32'b0001);
    cyc();
    chk("vidas_after_hit", 32'(dec_if.vidas), 2);
    wait_invuln("invuln_start");
    wait_window_end("invuln_end", w);
    chk("invuln_width", 32'(w), INV_CYCLES);

    // Hit and bonus during the window
    expect_ev(K_EN, 4'b0010, 4'd0);
    hit_req = 4'b0010;
    cyc();
    hit_req = 4'b0000;
    wait_invuln("invuln_second");
    chk("vidas_second_hit", 32'(dec_if.vidas), 1);
    hit_req = 4'b0100;
    cyc();
    hit_req = 4'b0000;
    chk("invuln_drop_ack", 32'(hit_ack), 32'b0100);
    chk("invuln_no_dec", 32'(dec_if.dec_en), 0);
    expect_ev(K_LD, 4'b0, 4'd2);
    bonus = 1'b1;
    cyc();
    bonus = 1'b0;
    wait_window_end("invuln_end_second", w);
    chk("vidas_kept_after_drop", 32'(dec_if.vidas), 1);
    cyc();
    chk("pending_bonus_ld", 32'(dec_if.dec_ld), 1);
    cyc();
    chk("vidas_after_bonus", 32'(dec_if.vidas), 2);

    // Bonus up to the ceiling, then one more that is discarded
    for (int v = 3; v <= MAX_VIDAS; v++) begin
      expect_ev(K_LD, 4'b0, 4'(v));
      bonus = 1'b1;
      cyc();
      bonus = 1'b0;
      cyc();
      chk("vidas_bonus_step", 32'(dec_if.vidas), 32'(v));
    end
    bonus = 1'b1;
    cyc();
    bonus = 1'b0;
    chk("bonus_at_max_no_ld", 32'(dec_if.dec_ld), 0);
    cyc();
    chk("vidas_capped", 32'(dec_if.vidas), MAX_VIDAS);

    // Restart in the middle of an invulnerability window
    expect_ev(K_EN, 4'b0100, 4'd0);
    hit_req = 4'b0100;
    cyc();
    hit_req = 4'b0000;
    wait_invuln("invuln_before_restart");
    cyc(3);
    expect_ev(K_CLR, 4'b0, 4'd0);
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    chk("restart_clr", 32'(dec_if.dec_clr), 1);
    chk("restart_invuln_low", 32'(invuln), 0);
    cyc();
    chk("restart_vidas", 32'(dec_if.vidas), 3);
    chk("restart_clr_one_cycle", 32'(dec_if.dec_clr), 0);

    // Same-cycle hit and bonus at vidas=2: decrement first, bonus after window
    expect_ev(K_EN, 4'b1000, 4'd0);
    hit_req = 4'b1000;
    cyc();
    hit_req = 4'b0000;
    wait_invuln("invuln_pre_combo");
    wait_window_end("invuln_end_pre_combo", w);
    chk("vidas_before_combo", 32'(dec_if.vidas), 2);
    expect_ev(K_EN, 4'b0001, 4'd0);
    expect_ev(K_LD, 4'b0, 4'd2);
    hit_req = 4'b0001;
    bonus   = 1'b1;
    cyc();
    hit_req = 4'b0000;
    bonus   = 1'b0;
    chk("combo_hit_wins", 32'({dec_if.dec_en, dec_if.dec_ld}), 32'b10);
    wait_invuln("invuln_combo");
    chk("vidas_combo_dec", 32'(dec_if.vidas), 1);
    wait_window_end("invuln_end_combo", w);
    cyc();
    chk("combo_bonus_ld", 32'(dec_if.dec_ld), 1);
    cyc();
    chk("vidas_combo_final", 32'(dec_if.vidas), 2);

    // Fresh reset, then all sources held until game over
    clr_n = 1'b0;
    cyc();
    chk("reset2_outputs", 32'({dec_if.dec_clr, dec_if.dec_en, dec_if.dec_ld, hit_ack,
                                invuln, game_over}), 0);
    expect_ev(K_CLR, 4'b0, 4'd0);
    clr_n = 1'b1;
    cyc(2);
    chk("reset2_vidas", 32'(dec_if.vidas), 3);
    expect_ev(K_EN, 4'b0001, 4'd0);
    expect_ev(K_EN, 4'b0010, 4'd0);
    expect_ev(K_EN, 4'b0100, 4'd0);
    hit_req = 4'b1111;
    w = 0;
    while (!game_over && w < 100) begin w++; cyc(); end
    chk("game_over_reached", 32'(game_over), 1);
    chk("vidas_zero_at_over", 32'(dec_if.vidas), 0);
    cyc();
    chk("over_drop_ack", 32'(hit_ack), 32'b1111);
    chk("over_no_dec", 32'(dec_if.dec_en), 0);
    bonus = 1'b1;
    cyc();
    bonus = 1'b0;
    cyc(5);
    chk("over_sticky", 32'(game_over), 1);
    chk("over_bonus_ignored", 32'(dec_if.vidas), 0);

    // Restart out of game over
    hit_req = 4'b0000;
    expect_ev(K_CLR, 4'b0, 4'd0);
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    chk("restart_over_clear", 32'({game_over, dec_if.dec_clr}), 32'b01);
    cyc();
    chk("restart_over_vidas", 32'(dec_if.vidas), 3);

    cyc(3);
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
